// File: rtl/lif_neuron_accum.sv
// Leaky integrate-and-fire accumulator: integrates signed weights per timestep, then
// applies leak, threshold, reset-to-zero and refractory hold when the fetch stage closes a step.
module lif_neuron_accum #(
    parameter int DATA_WIDTH   = 8,
    parameter int POT_WIDTH    = 16,
    parameter int THRESHOLD    = 100,
    parameter int LEAK_SHIFT   = 3,
    parameter int REFRAC_STEPS = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_weight_valid,
    input  logic [DATA_WIDTH-1:0]       i_weight_data,
    input  logic                        i_fetch_done,
    output logic                        o_spike,
    output logic                        o_update_done,
    output logic signed [POT_WIDTH-1:0] o_membrane,
    output logic                        o_refrac,
    output logic                        o_overrun
);

    localparam int PW = POT_WIDTH;
    localparam int RW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
    localparam logic signed [PW-1:0] THR     = PW'(THRESHOLD);
    localparam logic signed [PW-1:0] POT_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic signed [PW-1:0] POT_MIN = {1'b1, {(PW-1){1'b0}}};

    typedef enum logic [1:0] {S_ACCUM, S_LEAK, S_FIRE} state_t;

    state_t                 state_q;
    logic signed [PW-1:0]   acc_q;
    logic signed [PW-1:0]   snap_q;
    logic signed [PW-1:0]   v_next_q;
    logic [RW-1:0]          refrac_q;

    // In range only when the two guard bits match the POT_WIDTH sign bit.
    function automatic logic signed [PW-1:0] sat(input logic signed [PW+1:0] x);
        if (x[PW+1:PW-1] == 3'b000 || x[PW+1:PW-1] == 3'b111) begin
            return x[PW-1:0];
        end
        return x[PW+1] ? POT_MIN : POT_MAX;
    endfunction

    logic signed [PW+1:0] w_ext;
    logic signed [PW+1:0] acc_ext;
    logic signed [PW+1:0] v_ext;
    logic signed [PW+1:0] snap_ext;
    logic signed [PW-1:0] acc_add;
    logic signed [PW-1:0] leak_res;

    always_comb begin
        w_ext    = {{(PW+2-DATA_WIDTH){i_weight_data[DATA_WIDTH-1]}}, i_weight_data};
        acc_ext  = {{2{acc_q[PW-1]}}, acc_q};
        v_ext    = {{2{o_membrane[PW-1]}}, o_membrane};
        snap_ext = {{2{snap_q[PW-1]}}, snap_q};
        acc_add  = i_weight_valid ? sat(acc_ext + w_ext) : acc_q;
        leak_res = sat(v_ext - (v_ext >>> LEAK_SHIFT) + snap_ext);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_ACCUM;
            acc_q         <= '0;
            snap_q        <= '0;
            v_next_q      <= '0;
            refrac_q      <= '0;
            o_spike       <= 1'b0;
            o_update_done <= 1'b0;
            o_membrane    <= '0;
            o_refrac      <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            o_spike       <= 1'b0;
            o_update_done <= 1'b0;
            acc_q         <= acc_add;
            if (i_fetch_done && state_q != S_ACCUM) begin
                o_overrun <= 1'b1;
            end
            unique case (state_q)
                S_ACCUM: begin
                    if (i_fetch_done) begin
                        // A weight coincident with fetch_done closes with this timestep.
                        snap_q  <= acc_add;
                        acc_q   <= '0;
                        state_q <= S_LEAK;
                    end
                end
                S_LEAK: begin
                    v_next_q <= leak_res;
                    state_q  <= S_FIRE;
                end
                S_FIRE: begin
                    o_update_done <= 1'b1;
                    state_q       <= S_ACCUM;
                    if (refrac_q != '0) begin
                        refrac_q   <= refrac_q - 1'b1;
                        o_refrac   <= (refrac_q != RW'(1));
                        o_membrane <= '0;
                    end else if (v_next_q >= THR) begin
                        o_spike    <= 1'b1;
                        o_membrane <= '0;
                        refrac_q   <= RW'(REFRAC_STEPS);
                        o_refrac   <= (REFRAC_STEPS != 0);
                    end else begin
                        o_membrane <= v_next_q;
                    end
                end
                default: state_q <= S_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_lif_neuron_accum.sv
// Scoreboard bench for lif_neuron_accum: expected update results are queued at fetch_done
// and compared by a monitor on every o_update_done pulse.
module tb_lif_neuron_accum;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_weight_valid = 1'b0;
    logic [7:0]        i_weight_data = '0;
    logic              i_fetch_done = 1'b0;
    logic              o_spike;
    logic              o_update_done;
    logic signed [15:0] o_membrane;
    logic              o_refrac;
    logic              o_overrun;

    lif_neuron_accum dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_weight_valid (i_weight_valid),
        .i_weight_data  (i_weight_data),
        .i_fetch_done   (i_fetch_done),
        .o_spike        (o_spike),
        .o_update_done  (o_update_done),
        .o_membrane     (o_membrane),
        .o_refrac       (o_refrac),
        .o_overrun      (o_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              spike;
        logic signed [15:0] mem;
        logic              refrac;
    } exp_t;

    exp_t exp_q[$];
    int   wq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input logic s, input int m, input logic r);
        exp_t e;
        e.spike  = s;
        e.mem    = 16'(m);
        e.refrac = r;
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && o_update_done) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1 with no update pending, required none");
            end else begin
                e = exp_q.pop_front();
                if (o_spike !== e.spike) begin
                    errors++;
                    $display("FAIL sb_spike: got %0b required %0b", o_spike, e.spike);
                end
                checks++;
                if (o_membrane !== e.mem) begin
                    errors++;
                    $display("FAIL sb_membrane: got %0d required %0d", o_membrane, e.mem);
                end
                checks++;
                if (o_refrac !== e.refrac) begin
                    errors++;
                    $display("FAIL sb_refrac: got %0b required %0b", o_refrac, e.refrac);
                end
            end
        end
        if (rst_n && o_spike && !o_update_done) begin
            checks++;
            errors++;
            $display("FAIL spike_without_done: got spike=1 done=0 required done=1");
        end
    end

    // Drains wq one weight per cycle, pulses fetch_done, queues e, returns cycles to done.
    task automatic run_step(input exp_t e, output int lat);
        while (wq.size() > 0) begin
            @(posedge clk); #1;
            i_weight_valid = 1'b1;
            i_weight_data  = 8'(wq.pop_front());
        end
        @(posedge clk); #1;
        i_weight_valid = 1'b0;
        i_fetch_done   = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        i_fetch_done = 1'b0;
        lat = 1;
        while (!o_update_done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        i_weight_valid = 1'b0;
        i_fetch_done = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (o_spike !== 1'b0) begin errors++; $display("FAIL rst_spike: got %0b required 0", o_spike); end
        checks++; if (o_update_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b required 0", o_update_done); end
        checks++; if (o_membrane !== 16'sd0) begin errors++; $display("FAIL rst_membrane: got %0d required 0", o_membrane); end
        checks++; if (o_refrac !== 1'b0) begin errors++; $display("FAIL rst_refrac: got %0b required 0", o_refrac); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %0b required 0", o_overrun); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_fire();
        int lat;
        wq.push_back(40); wq.push_back(40); wq.push_back(30);
        run_step(mk(1'b1, 0, 1'b1), lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL fire_latency: got %0d required 3", lat); end
        checks++; if (o_spike !== 1'b1) begin errors++; $display("FAIL fire_spike: got %0b required 1", o_spike); end
    endtask

    task automatic test_refractory();
        int lat;
        wq.push_back(50);
        run_step(mk(1'b0, 0, 1'b1), lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL refrac1_latency: got %0d required 3", lat); end
        wq.push_back(50);
        run_step(mk(1'b0, 0, 1'b0), lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL refrac2_latency: got %0d required 3", lat); end
        wq.push_back(50);
        run_step(mk(1'b0, 50, 1'b0), lat);
        checks++; if (o_membrane !== 16'sd50) begin errors++; $display("FAIL refrac3_membrane: got %0d required 50", o_membrane); end
    endtask

    task automatic test_leak();
        int lat;
        run_step(mk(1'b0, 44, 1'b0), lat);
        run_step(mk(1'b0, 39, 1'b0), lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL leak_latency: got %0d required 3", lat); end
    endtask

    task automatic test_neg_sat();
        int lat;
        do_reset();
        for (int i = 0; i < 300; i++) wq.push_back(-128);
        run_step(mk(1'b0, -32768, 1'b0), lat);
        run_step(mk(1'b0, -28672, 1'b0), lat);
        checks++; if (o_membrane !== -16'sd28672) begin errors++; $display("FAIL negsat_leak: got %0d required -28672", o_membrane); end
    endtask

    task automatic test_coincide_overrun();
        int lat;
        do_reset();
        @(posedge clk); #1;
        i_weight_valid = 1'b1; i_weight_data = 8'd7; i_fetch_done = 1'b1;
        exp_q.push_back(mk(1'b0, 7, 1'b0));
        @(posedge clk); #1;
        // Now in the leak cycle: this weight goes to the next step, this fetch_done is an overrun.
        i_weight_valid = 1'b1; i_weight_data = 8'd5; i_fetch_done = 1'b1;
        @(posedge clk); #1;
        i_weight_valid = 1'b0; i_fetch_done = 1'b0;
        checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %0b required 1", o_overrun); end
        lat = 2;
        while (!o_update_done && lat < 10) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != 3) begin errors++; $display("FAIL coincide_latency: got %0d required 3", lat); end
        run_step(mk(1'b0, 12, 1'b0), lat);
        checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %0b required 1", o_overrun); end
        do_reset();
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %0b required 0", o_overrun); end
    endtask

    task automatic test_async_reset();
        int lat;
        int spikes;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            i_weight_valid = 1'b1; i_weight_data = (i == 0) ? 8'd60 : 8'd50;
        end
        @(posedge clk); #1;
        i_weight_valid = 1'b0; i_fetch_done = 1'b1;
        @(posedge clk); #1;
        i_fetch_done = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({o_spike, o_update_done, o_refrac, o_overrun} !== 4'b0) begin
            errors++; $display("FAIL async_rst_flags: got %b required 0000", {o_spike, o_update_done, o_refrac, o_overrun});
        end
        checks++; if (o_membrane !== 16'sd0) begin errors++; $display("FAIL async_rst_membrane: got %0d required 0", o_membrane); end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        spikes = 0;
        repeat (6) begin @(posedge clk); #1; if (o_spike || o_update_done) spikes++; end
        checks++; if (spikes != 0) begin errors++; $display("FAIL async_rst_no_pulse: got %0d required 0", spikes); end
        wq.push_back(3);
        run_step(mk(1'b0, 3, 1'b0), lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL async_rst_resume: got %0d required 3", lat); end
    endtask

    initial begin
        test_reset();
        test_fire();
        test_refractory();
        test_leak();
        test_neg_sat();
        test_coincide_overrun();
        test_async_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending updates required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

endmodule
